// File: rtl/axi_lite_arbiter_if.sv
// Signal bundle for the two-to-one AXI-Lite arbiter. The _i/_o suffixes are
// relative to the arbiter. The arbiter uses the slave modport. The master
// modport is the environment's view: it drives the upstream masters and acts
// as the downstream memory slave.
interface axi_lite_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // IFU (read only)
  logic                ifu_ar_valid_i;
  logic [ADDR_W-1:0]   ifu_ar_addr_i;
  logic                ifu_ar_ready_o;
  logic                ifu_r_valid_o;
  logic [DATA_W-1:0]   ifu_r_data_o;
  logic [1:0]          ifu_r_resp_o;
  logic                ifu_r_ready_i;
  // LSU (read and write)
  logic                lsu_ar_valid_i;
  logic [ADDR_W-1:0]   lsu_ar_addr_i;
  logic                lsu_ar_ready_o;
  logic                lsu_r_valid_o;
  logic [DATA_W-1:0]   lsu_r_data_o;
  logic [1:0]          lsu_r_resp_o;
  logic                lsu_r_ready_i;
  logic                lsu_aw_valid_i;
  logic [ADDR_W-1:0]   lsu_aw_addr_i;
  logic                lsu_aw_ready_o;
  logic                lsu_w_valid_i;
  logic [DATA_W-1:0]   lsu_w_data_i;
  logic [DATA_W/8-1:0] lsu_w_strb_i;
  logic                lsu_w_ready_o;
  logic                lsu_b_valid_o;
  logic [1:0]          lsu_b_resp_o;
  logic                lsu_b_ready_i;
  // Downstream memory port
  logic                mst_ar_valid_o;
  logic [ADDR_W-1:0]   mst_ar_addr_o;
  logic                mst_ar_ready_i;
  logic                mst_r_valid_i;
  logic [DATA_W-1:0]   mst_r_data_i;
  logic [1:0]          mst_r_resp_i;
  logic                mst_r_ready_o;
  logic                mst_aw_valid_o;
  logic [ADDR_W-1:0]   mst_aw_addr_o;
  logic                mst_aw_ready_i;
  logic                mst_w_valid_o;
  logic [DATA_W-1:0]   mst_w_data_o;
  logic [DATA_W/8-1:0] mst_w_strb_o;
  logic                mst_w_ready_i;
  logic                mst_b_valid_i;
  logic [1:0]          mst_b_resp_i;
  logic                mst_b_ready_o;

  modport slave (
    input  ifu_ar_valid_i, ifu_ar_addr_i, ifu_r_ready_i,
    output ifu_ar_ready_o, ifu_r_valid_o, ifu_r_data_o, ifu_r_resp_o,
    input  lsu_ar_valid_i, lsu_ar_addr_i, lsu_r_ready_i,
    input  lsu_aw_valid_i, lsu_aw_addr_i, lsu_w_valid_i, lsu_w_data_i,
    input  lsu_w_strb_i, lsu_b_ready_i,
    output lsu_ar_ready_o, lsu_r_valid_o, lsu_r_data_o, lsu_r_resp_o,
    output lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o,
    output mst_ar_valid_o, mst_ar_addr_o, mst_r_ready_o,
    output mst_aw_valid_o, mst_aw_addr_o, mst_w_valid_o, mst_w_data_o,
    output mst_w_strb_o, mst_b_ready_o,
    input  mst_ar_ready_i, mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
    input  mst_aw_ready_i, mst_w_ready_i, mst_b_valid_i, mst_b_resp_i
  );

  modport master (
    output ifu_ar_valid_i, ifu_ar_addr_i, ifu_r_ready_i,
    input  ifu_ar_ready_o, ifu_r_valid_o, ifu_r_data_o, ifu_r_resp_o,
    output lsu_ar_valid_i, lsu_ar_addr_i, lsu_r_ready_i,
    output lsu_aw_valid_i, lsu_aw_addr_i, lsu_w_valid_i, lsu_w_data_i,
    output lsu_w_strb_i, lsu_b_ready_i,
    input  lsu_ar_ready_o, lsu_r_valid_o, lsu_r_data_o, lsu_r_resp_o,
    input  lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o,
    input  mst_ar_valid_o, mst_ar_addr_o, mst_r_ready_o,
    input  mst_aw_valid_o, mst_aw_addr_o, mst_w_valid_o, mst_w_data_o,
    input  mst_w_strb_o, mst_b_ready_o,
    output mst_ar_ready_i, mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
    output mst_aw_ready_i, mst_w_ready_i, mst_b_valid_i, mst_b_resp_i
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-to-one AXI-Lite arbiter: IFU (read) and LSU (read/write) share one
// downstream port. One whole transaction is granted at a time, and the grant
// is held from the address handshake to the final response. In a grant state
// all channels pass through combinationally.
module axi_lite_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  axi_lite_arbiter_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    GNT_IFU_R = 4'b0010,
    GNT_LSU_R = 4'b0100,
    GNT_LSU_W = 4'b1000
  } state_t;

  state_t r_state;
  state_t w_next;

  // Completed address/data handshakes in the current grant. They block
  // duplicate AR/AW/W forwarding and keep responses closed until a request
  // has actually been accepted downstream.
  logic r_ar_done;
  logic r_aw_done;
  logic r_w_done;

  logic [ADDR_W-1:0]   w_ar_addr;
  logic [DATA_W-1:0]   w_r_data;
  logic [DATA_W/8-1:0] w_w_strb;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Handshake tracking; cleared whenever the grant ends
  always_ff @(posedge clk_i) begin
    if (rst_i || (w_next == IDLE)) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (bus.mst_ar_valid_o && bus.mst_ar_ready_i) r_ar_done <= 1'b1;
      if (bus.mst_aw_valid_o && bus.mst_aw_ready_i) r_aw_done <= 1'b1;
      if (bus.mst_w_valid_o  && bus.mst_w_ready_i)  r_w_done  <= 1'b1;
    end
  end

  // Arbitration, next state and channel routing
  always_comb begin
    w_next    = r_state;
    w_ar_addr = '0;
    w_r_data  = '0;
    w_w_strb  = '0;

    bus.ifu_ar_ready_o = 1'b0;
    bus.ifu_r_valid_o  = 1'b0;
    bus.ifu_r_data_o   = '0;
    bus.ifu_r_resp_o   = '0;
    bus.lsu_ar_ready_o = 1'b0;
    bus.lsu_r_valid_o  = 1'b0;
    bus.lsu_r_data_o   = '0;
    bus.lsu_r_resp_o   = '0;
    bus.lsu_aw_ready_o = 1'b0;
    bus.lsu_w_ready_o  = 1'b0;
    bus.lsu_b_valid_o  = 1'b0;
    bus.lsu_b_resp_o   = '0;
    bus.mst_ar_valid_o = 1'b0;
    bus.mst_r_ready_o  = 1'b0;
    bus.mst_aw_valid_o = 1'b0;
    bus.mst_aw_addr_o  = '0;
    bus.mst_w_valid_o  = 1'b0;
    bus.mst_w_data_o   = '0;
    bus.mst_b_ready_o  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if      (bus.lsu_ar_valid_i) w_next = GNT_LSU_R;
        else if (bus.lsu_aw_valid_i) w_next = GNT_LSU_W;
        else if (bus.ifu_ar_valid_i) w_next = GNT_IFU_R;
      end

      GNT_IFU_R: begin
        w_ar_addr          = bus.ifu_ar_addr_i;
        w_r_data           = bus.mst_r_data_i;
        bus.mst_ar_valid_o = bus.ifu_ar_valid_i & ~r_ar_done;
        bus.ifu_ar_ready_o = bus.mst_ar_ready_i & ~r_ar_done;
        bus.ifu_r_valid_o  = bus.mst_r_valid_i & r_ar_done;
        bus.mst_r_ready_o  = bus.ifu_r_ready_i & r_ar_done;
        bus.ifu_r_data_o   = w_r_data;
        bus.ifu_r_resp_o   = bus.mst_r_resp_i;
        if (bus.mst_r_valid_i && bus.ifu_r_ready_i && r_ar_done) w_next = IDLE;
      end

      GNT_LSU_R: begin
        w_ar_addr          = bus.lsu_ar_addr_i;
        w_r_data           = bus.mst_r_data_i;
        bus.mst_ar_valid_o = bus.lsu_ar_valid_i & ~r_ar_done;
        bus.lsu_ar_ready_o = bus.mst_ar_ready_i & ~r_ar_done;
        bus.lsu_r_valid_o  = bus.mst_r_valid_i & r_ar_done;
        bus.mst_r_ready_o  = bus.lsu_r_ready_i & r_ar_done;
        bus.lsu_r_data_o   = w_r_data;
        bus.lsu_r_resp_o   = bus.mst_r_resp_i;
        if (bus.mst_r_valid_i && bus.lsu_r_ready_i && r_ar_done) w_next = IDLE;
      end

      GNT_LSU_W: begin
        w_w_strb           = bus.lsu_w_strb_i;
        bus.mst_aw_valid_o = bus.lsu_aw_valid_i & ~r_aw_done;
        bus.mst_aw_addr_o  = bus.lsu_aw_addr_i;
        bus.lsu_aw_ready_o = bus.mst_aw_ready_i & ~r_aw_done;
        bus.mst_w_valid_o  = bus.lsu_w_valid_i & ~r_w_done;
        bus.mst_w_data_o   = bus.lsu_w_data_i;
        bus.lsu_w_ready_o  = bus.mst_w_ready_i & ~r_w_done;
        bus.lsu_b_valid_o  = bus.mst_b_valid_i & r_aw_done & r_w_done;
        bus.mst_b_ready_o  = bus.lsu_b_ready_i & r_aw_done & r_w_done;
        bus.lsu_b_resp_o   = bus.mst_b_resp_i;
        if (bus.mst_b_valid_i && bus.lsu_b_ready_i && r_aw_done && r_w_done)
          w_next = IDLE;
      end

      default: w_next = IDLE;
    endcase

    bus.mst_ar_addr_o = w_ar_addr;
    bus.mst_w_strb_o  = w_w_strb;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-to-one AXI-Lite arbiter between the core's bus masters and the single memory-side AXI-Lite port. The upstream masters are the instruction fetch unit (read-only) and the load/store unit (read and write). The block grants one whole transaction at a time and holds the grant from address handshake to final response. All other signals pass through combinationally once granted.

## Interface
Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8

Ports (per-channel signal groups listed valid/payload/ready; widths in the same order):
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- ifu_ar_valid_i / ifu_ar_addr_i / ifu_ar_ready_o  in/in/out  1/ADDR_W/1  IFU read address
- ifu_r_valid_o / ifu_r_data_o / ifu_r_resp_o / ifu_r_ready_i  out/out/out/in  1/DATA_W/2/1  IFU read data
- lsu_ar_valid_i / lsu_ar_addr_i / lsu_ar_ready_o  in/in/out  1/ADDR_W/1  LSU read address
- lsu_r_valid_o / lsu_r_data_o / lsu_r_resp_o / lsu_r_ready_i  out/out/out/in  1/DATA_W/2/1  LSU read data
- lsu_aw_valid_i / lsu_aw_addr_i / lsu_aw_ready_o  in/in/out  1/ADDR_W/1  LSU write address
- lsu_w_valid_i / lsu_w_data_i / lsu_w_strb_i / lsu_w_ready_o  in/in/in/out  1/DATA_W/DATA_W/8/1  LSU write data
- lsu_b_valid_o / lsu_b_resp_o / lsu_b_ready_i  out/out/in  1/2/1  LSU write response
- mst_ar_valid_o / mst_ar_addr_o / mst_ar_ready_i  out/out/in  1/ADDR_W/1  downstream read address
- mst_r_valid_i / mst_r_data_i / mst_r_resp_i / mst_r_ready_o  in/in/in/out  1/DATA_W/2/1  downstream read data
- mst_aw_valid_o / mst_aw_addr_o / mst_aw_ready_i  out/out/in  1/ADDR_W/1  downstream write address
- mst_w_valid_o / mst_w_data_o / mst_w_strb_o / mst_w_ready_i  out/out/out/in  1/DATA_W/DATA_W/8/1  downstream write data
- mst_b_valid_i / mst_b_resp_i / mst_b_ready_o  in/in/out  1/2/1  downstream write response

## Operation
- State machine is one-hot with four states: IDLE, GNT_IFU_R, GNT_LSU_R, GNT_LSU_W.
- IDLE: all ready/valid outputs are 0 on both sides, and all payload outputs are 0. Requests are sampled in this state; no handshake completes in IDLE.
- IDLE arbitration is fixed priority: lsu_ar_valid_i wins and the next state is GNT_LSU_R. Otherwise lsu_aw_valid_i gives GNT_LSU_W. Otherwise ifu_ar_valid_i gives GNT_IFU_R. With no request, the state stays IDLE.
- GNT_IFU_R and GNT_LSU_R: the granted master's AR and R channels connect to mst_ar_*/mst_r_*. The non-granted side sees ready=0 and valid=0. The write channels stay idle.
- GNT_LSU_R and GNT_IFU_R exit to IDLE on the mst_r handshake (mst_r_valid_i & granted r_ready). Reaching that point requires an AR handshake first.
- GNT_LSU_W: lsu_aw/lsu_w/lsu_b connect to mst_aw/mst_w/mst_b. AW and W handshakes are independent; the W handshake may come before or with AW. Exit to IDLE on the mst_b handshake.
- Response payloads (data, resp) are forwarded unmodified; SLVERR/DECERR reach the master as received. The arbiter never generates a response itself.
- At most one transaction is outstanding on mst_*. A second AR from the same master inside a grant is not forwarded until the R handshake ends the grant.

## Timing
- Reset: state = IDLE; every output = 0.
- Arbitration latency is exactly one cycle. A request first visible at cycle N in IDLE appears on mst_*_valid_o at N+1.
- Back-to-back transactions have one IDLE bubble cycle between a final handshake and the next grant.
- Pass-through in a grant state is combinational in both directions, with no added latency. Downstream ready/valid stalls propagate the same cycle.
- Masters must hold valid and payload stable until handshake. The arbiter does not latch addresses or data.
- Simultaneous LSU AR and AW in IDLE: the read is served first, and AW remains pending until the next IDLE.
- Reset mid-grant forces IDLE next cycle and drops the in-flight transaction. Downstream is reset by the same rst_i.
- Starvation of the IFU is accepted by design, because the LSU issues at most one request per instruction.

## Test plan
- IFU read alone: ifu_ar addr 0x8000_0000, slave responds after 3 cycles with data 0x0000_0413, resp OKAY -> mst_ar_valid_o rises 1 cycle after request; ifu_r_data_o = 0x0000_0413; state returns to IDLE the cycle after the R handshake.
- Same-cycle IFU AR 0x8000_0004 and LSU AR 0x8000_1000 -> LSU is granted first and mst_ar_addr_o = 0x8000_1000. After LSU R completes plus one IDLE cycle, mst_ar_addr_o = 0x8000_0004. ifu_ar_ready_o stays 0 throughout the LSU grant.
- LSU write: aw 0xA000_03F8, w data 0x0000_0041 strb 0x1, slave accepts W before AW, B resp OKAY after 2 cycles -> mst_w_strb_o = 0x1; lsu_b_valid_o is pulsed; the IFU request held during the write is granted only after B.
- Stalls: mst_ar_ready_i low for 5 cycles, then mst_r_valid_i high while lsu_r_ready_i is low for 2 cycles -> grant is held, mst_r_ready_o mirrors lsu_r_ready_i, no duplicate AR, exactly one R handshake.
- Error pass-through: slave returns R resp DECERR (2'b11) for addr 0x0000_0000 -> lsu_r_resp_o = 2'b11 and the FSM returns to IDLE normally.
- Reset during GNT_LSU_W before B -> next cycle all outputs are 0 and state is IDLE. A new IFU read afterward completes normally.
